// File: rtl/keypad_lock_ctrl.sv
// Combination-lock session controller for the 3x4 keypad: digit capture, clear,
// enter/compare, timed unlock window, failed-attempt counting and timed lockout.
module keypad_lock_ctrl #(
  parameter logic [15:0] CODE           = 16'h1234,
  parameter int          MAX_TRIES      = 3,
  parameter int          OPEN_CYCLES    = 150000000,
  parameter int          LOCKOUT_CYCLES = 250000000,
  parameter int          CNT_W          = 28
) (
  input  logic        CLOCK_50,
  input  logic        RST_N,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] digits,
  output logic [3:0]  digits_en,
  output logic        unlocked,
  output logic        locked_out,
  output logic        err_pulse,
  output logic [2:0]  fail_cnt
);

  // state   | meaning
  // IDLE    | no digits entered, waiting for a key
  // ENTRY   | 1..4 digits captured
  // CHECK   | compare captured digits against CODE
  // FAIL    | one-cycle wrong-attempt bookkeeping
  // OPEN    | unlock window running
  // LOCKOUT | too many failures, keys ignored until timer expires
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, FAIL, OPEN, LOCKOUT} state_t;

  localparam logic [CNT_W-1:0] OPEN_TC    = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCKOUT_TC = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]       TRIES_MAX  = 3'(MAX_TRIES);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   timer, timer_nxt;
  logic [15:0]        digits_nxt;
  logic [3:0]         en_nxt;
  logic [2:0]         fail_nxt;
  logic               is_digit, is_star, is_hash, full;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_star  = key_valid && (key_code == 4'd10);
  assign is_hash  = key_valid && (key_code == 4'd11);
  // digits_en doubles as the digit count, so the thermometer is full at four digits
  assign full     = digits_en[3];

  always_comb begin
    state_nxt  = state;
    digits_nxt = digits;
    en_nxt     = digits_en;
    fail_nxt   = fail_cnt;
    case (state)
      IDLE, ENTRY: begin
        if (is_digit) begin
          if (!full) begin
            digits_nxt = {digits[11:0], key_code};
            en_nxt     = {digits_en[2:0], 1'b1};
            state_nxt  = ENTRY;
          end
        end else if (is_star) begin
          digits_nxt = '0;
          en_nxt     = '0;
          state_nxt  = IDLE;
        end else if (is_hash) begin
          if (full) begin
            state_nxt = CHECK;
          end else begin
            digits_nxt = '0;
            en_nxt     = '0;
            fail_nxt   = fail_cnt + 3'd1;
            state_nxt  = FAIL;
          end
        end
      end
      CHECK: begin
        digits_nxt = '0;
        en_nxt     = '0;
        if (digits == CODE) begin
          fail_nxt  = '0;
          state_nxt = OPEN;
        end else begin
          fail_nxt  = fail_cnt + 3'd1;
          state_nxt = FAIL;
        end
      end
      FAIL: begin
        // fail_cnt was already bumped on the way into FAIL
        state_nxt = (fail_cnt == TRIES_MAX) ? LOCKOUT : IDLE;
      end
      OPEN: begin
        if (is_star || timer == OPEN_TC) state_nxt = IDLE;
      end
      LOCKOUT: begin
        if (timer == LOCKOUT_TC) begin
          fail_nxt  = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        digits_nxt = '0;
        en_nxt     = '0;
        state_nxt  = IDLE;
      end
    endcase

    timer_nxt = '0;
    if (state_nxt == state && (state == OPEN || state == LOCKOUT)) timer_nxt = timer + 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      timer      <= '0;
      digits     <= '0;
      digits_en  <= '0;
      fail_cnt   <= '0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      digits     <= digits_nxt;
      digits_en  <= en_nxt;
      fail_cnt   <= fail_nxt;
      unlocked   <= (state_nxt == OPEN);
      locked_out <= (state_nxt == LOCKOUT);
      err_pulse  <= (state_nxt == FAIL);
    end
  end

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Directed bench for keypad_lock_ctrl with short timers (OPEN 8, LOCKOUT 16).
module tb_keypad_lock_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic        RST_N;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] digits;
  logic [3:0]  digits_en;
  logic        unlocked;
  logic        locked_out;
  logic        err_pulse;
  logic [2:0]  fail_cnt;
  logic [25:0] all_out;

  int n_checks = 0;
  int n_errors = 0;

  keypad_lock_ctrl #(
    .CODE(16'h1234), .MAX_TRIES(3), .OPEN_CYCLES(8), .LOCKOUT_CYCLES(16), .CNT_W(28)
  ) dut (
    .CLOCK_50(CLOCK_50), .RST_N(RST_N), .key_valid(key_valid), .key_code(key_code),
    .digits(digits), .digits_en(digits_en), .unlocked(unlocked), .locked_out(locked_out),
    .err_pulse(err_pulse), .fail_cnt(fail_cnt)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  assign all_out = {digits, digits_en, unlocked, locked_out, err_pulse, fail_cnt};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge CLOCK_50);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge CLOCK_50);
    key_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] lock_keys [5];
    int n;
    lock_keys = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd11};
    RST_N = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    repeat (3) @(negedge CLOCK_50);
    check("reset_outs", 32'(all_out), 32'h0);
    RST_N = 1'b1;
    @(negedge CLOCK_50);
    check("post_release_outs", 32'(all_out), 32'h0);

    // correct code, full unlock window
    press(1); press(2); press(3); press(4);
    check("t1_digits", 32'(digits), 32'h1234);
    check("t1_en", 32'(digits_en), 32'hF);
    press(11);
    check("t1_check_unlocked", 32'(unlocked), 32'h0);
    @(negedge CLOCK_50);
    check("t1_unlocked", 32'(unlocked), 32'h1);
    check("t1_open_digits", 32'(digits), 32'h0);
    n = 0;
    for (int i = 0; i < 40 && unlocked; i++) begin n++; @(negedge CLOCK_50); end
    check("t1_open_len", 32'(n), 32'd8);
    check("t1_after_fail_cnt", 32'(fail_cnt), 32'h0);
    check("t1_after_en", 32'(digits_en), 32'h0);

    // wrong code
    press(1); press(2); press(3); press(5); press(11);
    check("t2_err_early", 32'(err_pulse), 32'h0);
    @(negedge CLOCK_50);
    check("t2_err", 32'(err_pulse), 32'h1);
    check("t2_fail_cnt", 32'(fail_cnt), 32'h1);
    check("t2_digits", 32'(digits), 32'h0);
    @(negedge CLOCK_50);
    check("t2_err_one_cycle", 32'(err_pulse), 32'h0);
    check("t2_unlocked", 32'(unlocked), 32'h0);

    // second and third failures, then lockout
    press(5); press(5); press(5); press(5); press(11);
    repeat (2) @(negedge CLOCK_50);
    check("t3_fail_cnt2", 32'(fail_cnt), 32'h2);
    press(1); press(11);
    check("t3_short_err", 32'(err_pulse), 32'h1);
    check("t3_fail_cnt3", 32'(fail_cnt), 32'h3);
    @(negedge CLOCK_50);
    check("t3_locked", 32'(locked_out), 32'h1);
    n = 0;
    for (int i = 0; i < 60 && locked_out; i++) begin
      n++;
      if (i >= 2 && i < 7) begin key_valid = 1'b1; key_code = lock_keys[i-2]; end
      else key_valid = 1'b0;
      @(negedge CLOCK_50);
    end
    key_valid = 1'b0;
    check("t3_lock_len", 32'(n), 32'd16);
    check("t3_after_fail_cnt", 32'(fail_cnt), 32'h0);
    check("t3_after_digits", 32'(digits), 32'h0);
    check("t3_after_unlocked", 32'(unlocked), 32'h0);

    // clear, fifth digit ignored, early relock
    press(9); press(8);
    check("t4_digits98", 32'(digits), 32'h0098);
    check("t4_en98", 32'(digits_en), 32'h3);
    press(10);
    check("t4_star_digits", 32'(digits), 32'h0);
    check("t4_star_en", 32'(digits_en), 32'h0);
    press(1); press(2); press(3); press(4); press(5);
    check("t4_fifth_ignored", 32'(digits), 32'h1234);
    check("t4_err_none", 32'(err_pulse), 32'h0);
    press(11);
    @(negedge CLOCK_50);
    repeat (2) @(negedge CLOCK_50);
    check("t4_open_c2", 32'(unlocked), 32'h1);
    press(10);
    check("t4_relock", 32'(unlocked), 32'h0);
    press(7);
    check("t4_idle_digit", 32'(digits), 32'h0007);
    check("t4_idle_en", 32'(digits_en), 32'h1);

    // invalid code, keys during CHECK/FAIL, back-to-back pulses
    press(13);
    check("t5_invalid_digits", 32'(digits), 32'h0007);
    check("t5_invalid_en", 32'(digits_en), 32'h1);
    press(10);
    press(1); press(2); press(3); press(9);
    @(negedge CLOCK_50); key_valid = 1'b1; key_code = 4'd11;
    @(negedge CLOCK_50); key_code = 4'd4;
    check("t5_check_digits", 32'(digits), 32'h1239);
    @(negedge CLOCK_50); key_code = 4'd4;
    check("t5_fail_err", 32'(err_pulse), 32'h1);
    check("t5_fail_cnt", 32'(fail_cnt), 32'h1);
    @(negedge CLOCK_50); key_valid = 1'b0;
    check("t5_dropped_digits", 32'(digits), 32'h0);
    check("t5_dropped_en", 32'(digits_en), 32'h0);
    @(negedge CLOCK_50); key_valid = 1'b1; key_code = 4'd1;
    @(negedge CLOCK_50); key_code = 4'd2;
    @(negedge CLOCK_50); key_valid = 1'b0;
    check("t5_b2b_digits", 32'(digits), 32'h0012);
    check("t5_b2b_en", 32'(digits_en), 32'h3);
    press(10);

    // asynchronous reset mid-OPEN
    press(1); press(2); press(3); press(4); press(11);
    @(negedge CLOCK_50);
    repeat (4) @(negedge CLOCK_50);
    check("t6_open_c4", 32'(unlocked), 32'h1);
    #2 RST_N = 1'b0;
    #1 check("t6_rst_open", 32'(all_out), 32'h0);
    @(negedge CLOCK_50); RST_N = 1'b1;
    press(6);
    check("t6_first_key", 32'(digits), 32'h0006);
    press(10);

    // asynchronous reset mid-LOCKOUT
    press(11); @(negedge CLOCK_50);
    press(11); @(negedge CLOCK_50);
    press(11); @(negedge CLOCK_50);
    repeat (5) @(negedge CLOCK_50);
    check("t6_lock_c5", 32'(locked_out), 32'h1);
    check("t6_lock_fail_cnt", 32'(fail_cnt), 32'h3);
    #2 RST_N = 1'b0;
    #1 check("t6_rst_lock", 32'(all_out), 32'h0);
    @(negedge CLOCK_50); RST_N = 1'b1;
    press(4);
    check("t6_lock_first_key", 32'(digits), 32'h0004);
    check("t6_lock_first_en", 32'(digits_en), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_lock_ctrl.md
# keypad_lock_ctrl

Code-entry controller for the 3x4 keypad: consumes the scanner's debounced key events and sequences a 4-digit combination-lock session. It covers digit capture, clear, enter/compare, a timed unlock window, a failed-attempt counter and a timed lockout. It drives the digit registers shown on HEX0-HEX3 and the status LEDs, and sits between the scanner/key-latch path and the seven-segment decoders in the top-level puzzle design.

## Interface
- CODE, 16'h1234: secret combination, 4 BCD digits, [15:12] entered first.
- MAX_TRIES, 3: consecutive failed attempts that trigger lockout (1..7).
- OPEN_CYCLES, 150000000: unlock window length in CLOCK_50 cycles (3 s).
- LOCKOUT_CYCLES, 250000000: lockout length in CLOCK_50 cycles (5 s).
- CNT_W, 28: timer width; must hold max(OPEN_CYCLES, LOCKOUT_CYCLES)-1.

Ports:
- CLOCK_50  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle pulse per key press, synchronous to CLOCK_50.
- key_code  in  4  key value, qualified by key_valid: 0-9 digits, 10 = '*', 11 = '#', 12-15 invalid.
- digits  out  16  entered digits, most recent in [3:0].
- digits_en  out  4  thermometer blanking mask for the display, bit i = 1 when digit i is valid.
- unlocked  out  1  high during the unlock window.
- locked_out  out  1  high during lockout.
- err_pulse  out  1  one-cycle pulse on every failed attempt.
- fail_cnt  out  3  consecutive failed attempts so far.

## Operation
- States: IDLE, ENTRY, CHECK, FAIL, OPEN, LOCKOUT.
- Reset values: state IDLE, digits 0, digits_en 0, unlocked 0, locked_out 0, err_pulse 0, fail_cnt 0, timer 0.
- A key is accepted only when key_valid = 1 in IDLE or ENTRY, or when it is '*' in OPEN. All others are dropped, including keys arriving in CHECK, FAIL or LOCKOUT.
- Invalid codes (12-15) are always ignored, with no state change.
- Digit in IDLE/ENTRY with count < 4: digits <= {digits[11:0], key_code}, count+1, state ENTRY.
- Digit with count = 4: ignored. Digits are unchanged and no error is raised.
- '*' in IDLE/ENTRY: digits 0, count 0, state IDLE. fail_cnt is unchanged.
- '#' in IDLE/ENTRY:
  - count = 4 -> CHECK.
  - count < 4 -> FAIL, counted as a wrong attempt.
- CHECK (1 cycle):
  - digits == CODE -> OPEN, fail_cnt <= 0.
  - otherwise -> FAIL.
- FAIL (1 cycle): err_pulse = 1, fail_cnt+1, digits and count cleared.
  - new fail_cnt == MAX_TRIES -> LOCKOUT.
  - otherwise -> IDLE.
- OPEN: unlocked = 1 and digits are cleared on entry. The timer counts from 0.
  - State exits to IDLE after exactly OPEN_CYCLES cycles.
  - '*' exits to IDLE on the next edge (early relock).
- LOCKOUT: locked_out = 1 and the timer counts from 0. After exactly LOCKOUT_CYCLES cycles the state goes to IDLE and fail_cnt <= 0.
- The timer is cleared on every state transition. Terminal condition is timer == N-1.
- digits_en = 4'b0000, 0001, 0011, 0111, 1111 for count 0..4.

## Timing
- Edge t is the edge at which key_valid is sampled high. All outputs are registered and none is combinational from inputs.
- Digit accepted at edge t: digits and digits_en update after edge t.
- '#' with 4 digits at edge t:
  - CHECK after edge t.
  - unlocked = 1 or err_pulse = 1 after edge t+1.
  - For a failure, IDLE or LOCKOUT follows after edge t+2.
- unlocked stays high for exactly OPEN_CYCLES cycles, or falls the edge after an accepted '*'.
- locked_out stays high for exactly LOCKOUT_CYCLES cycles.
- Back-to-back key_valid pulses on consecutive cycles are each processed, as long as the state accepts them.
- RST_N low at any time, including mid-OPEN or mid-LOCKOUT, forces all reset values immediately, asynchronously. Release is synchronous to the next CLOCK_50 edge.

## Test plan
Benches override the parameters to CODE = 16'h1234, MAX_TRIES = 3, OPEN_CYCLES = 8, LOCKOUT_CYCLES = 16.

- Keys 1,2,3,4,# -> digits 16'h1234, digits_en 4'hF. Then CHECK, then unlocked = 1 for exactly 8 cycles, then IDLE with digits 0 and fail_cnt 0.
- Keys 1,2,3,5,# -> one err_pulse, fail_cnt = 1, digits 0, state IDLE, unlocked stays 0.
- Three wrong entries, with the third being a short '1,#' -> fail_cnt 1, 2, 3, then locked_out = 1 for 16 cycles. Keys 1,2,3,4,# pressed during lockout have no effect. Afterward fail_cnt = 0 and state IDLE.
- Keys 9,8,*,1,2,3,4,5,# -> '*' clears, the 5th digit is ignored, digits 16'h1234, unlock. In OPEN, '*' at cycle 3 drops unlocked on the next edge.
- Invalid code 13 and key_valid pulses during CHECK/FAIL -> no change. Back-to-back digit pulses 1,2 on consecutive cycles -> digits 16'h0012.
- RST_N asserted at OPEN cycle 4 and again at LOCKOUT cycle 5 -> all outputs zero immediately. The first key after release is accepted normally.
